// File: rtl/dl_spec_checker.sv
// dl_spec_checker: response checker for a gate-level D latch (tracks expected Q, skips settling samples, counts errors)
module dl_spec_checker #(
  parameter int CNT_W    = 16,
  parameter int SETTLE_N = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             finish,
  input  logic             sample_valid,
  input  logic             d,
  input  logic             e,
  input  logic             q,
  input  logic             qb,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] chk_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_flag,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [1:0]       first_err_code
);
  typedef enum logic [1:0] {IDLE, UNKNOWN, KNOWN, DONE} state_t;
  localparam int SW = $clog2(SETTLE_N + 2);
  // the change sample itself is the first settling sample, so the counter holds the remainder
  localparam logic [SW-1:0] LOAD = SW'(SETTLE_N > 0 ? SETTLE_N - 1 : 0);
  state_t state, state_nx;
  logic [SW-1:0] settle_cnt, settle_nx;
  logic [1:0] prev_de, code;
  logic first, exp_q, acc, change, settling, vchk, exp_v;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction
  assign busy = (state == UNKNOWN) || (state == KNOWN);
  assign done = (state == DONE);
  assign pass = done && (err_cnt == '0) && (chk_cnt != '0);
  // sample classification: acceptance, change/settle detection and error code
  always_comb begin
    acc       = busy && sample_valid && !start && !finish;
    change    = first || ({d, e} != prev_de);
    settling  = change ? (SETTLE_N != 0) : (settle_cnt != '0);
    settle_nx = change ? LOAD : (settle_cnt != '0) ? settle_cnt - SW'(1) : settle_cnt;
    vchk      = !settling && (e || state == KNOWN);
    exp_v     = e ? d : exp_q;
    code      = settling ? 2'b00 : {vchk && (q != exp_v), qb == q};
  end
  // run-control next state; start wins over finish
  always_comb begin
    state_nx = state;
    if (start) state_nx = UNKNOWN;
    else if (finish && busy) state_nx = DONE;
    else if (acc && e && state == UNKNOWN) state_nx = KNOWN;
  end
  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // counters, expected-Q tracking and first-error capture
  always_ff @(posedge clk) begin
    if (!rst_n || start) begin
      sample_cnt     <= '0;
      chk_cnt        <= '0;
      err_cnt        <= '0;
      err_flag       <= 1'b0;
      first_err_idx  <= '0;
      first_err_code <= 2'b00;
      exp_q          <= 1'b0;
      settle_cnt     <= '0;
      prev_de        <= 2'b00;
      first          <= rst_n;
    end else if (acc) begin
      sample_cnt <= sat_inc(sample_cnt);
      first      <= 1'b0;
      prev_de    <= {d, e};
      settle_cnt <= settle_nx;
      if (vchk) chk_cnt <= sat_inc(chk_cnt);
      if (e) exp_q <= d;
      if (code != 2'b00) begin
        err_cnt <= sat_inc(err_cnt);
        if (!err_flag) begin
          err_flag       <= 1'b1;
          first_err_idx  <= sample_cnt;
          first_err_code <= code;
        end
      end
    end
  end
endmodule
